// File: rtl/dmem_write_buffer_pkg.sv
// Shared constants for the posted-store write buffer (depth, widths, word-address slice).
package dmem_write_buffer_pkg;

    localparam int unsigned WB_DEPTH = 4;
    localparam int unsigned WB_AW    = 32;
    localparam int unsigned WB_DW    = 32;
    // Matching ignores the byte offset: word address is addr[AW-1:WORD_LSB].
    localparam int unsigned WORD_LSB = 2;

endpackage

// File: rtl/dwb_match.sv
// Word-address match across buffer entries: per-entry hit vector plus the youngest hit,
// with age measured from the head pointer. Shared by forwarding and coalescing.
module dwb_match
    import dmem_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned WAW   = WB_AW - WORD_LSB,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]          valid,
    input  logic [DEPTH-1:0][WAW-1:0] waddr,
    input  logic [PTR_W-1:0]          head,
    input  logic [WAW-1:0]            lookup,
    output logic [DEPTH-1:0]          hit,
    output logic [PTR_W-1:0]          hit_idx,
    output logic                      any_hit
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (waddr[i] == lookup);
        end
    end

    assign any_hit = |hit;

    // Valid entries are contiguous from head, so walking oldest-to-youngest and
    // keeping the last hit yields the youngest match.
    always_comb begin
        hit_idx = head;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = PTR_W'(head + k);
            if (hit[idx]) begin
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer between the CPU MEM stage and data memory, with store-to-load forwarding.
// Optional in-place store merging into non-head entries when DWB_COALESCE_EN is defined.
module dmem_write_buffer
    import dmem_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DW    = WB_DW
) (
    input  logic          CLK,
    input  logic          MRST,
    input  logic [AW-1:0] Daddr,
    input  logic          Dread,
    input  logic          Dwrite,
    input  logic [DW-1:0] Dout,
    output logic [DW-1:0] Din,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wreq,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wack,
    output logic          wb_full,
    output logic          wb_empty,
    output logic          wb_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned WAW   = AW - WORD_LSB;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0][AW-1:0]  e_addr;
    logic [DEPTH-1:0][DW-1:0]  e_data;
    logic [DEPTH-1:0][WAW-1:0] e_waddr;
    logic [DEPTH-1:0]          e_valid;
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [PTR_W:0]            count;
    logic                      overflow_q;

    logic [DEPTH-1:0]          hit;
    logic [PTR_W-1:0]          hit_idx;
    logic                      any_hit;
    logic                      pop;
    logic                      coalesce;
    logic                      alloc;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            e_waddr[i] = e_addr[i][AW-1:WORD_LSB];
        end
    end

    dwb_match #(
        .DEPTH (DEPTH),
        .WAW   (WAW),
        .PTR_W (PTR_W)
    ) u_match (
        .valid   (e_valid),
        .waddr   (e_waddr),
        .head    (head),
        .lookup  (Daddr[AW-1:WORD_LSB]),
        .hit     (hit),
        .hit_idx (hit_idx),
        .any_hit (any_hit)
    );

    assign wb_empty    = (count == '0);
    assign wb_full     = (count == FULL_CNT);
    assign wb_overflow = overflow_q;
    assign mem_wreq    = !wb_empty;
    assign mem_waddr   = e_addr[head];
    assign mem_wdata   = e_data[head];
    assign mem_raddr   = Daddr;
    assign pop         = mem_wreq && mem_wack;

`ifdef DWB_COALESCE_EN
    logic [DEPTH-1:0] head_hot;
    assign head_hot = DEPTH'(1) << head;
    // The head is excluded so mem_wdata stays stable while it drains; when a
    // non-head entry hits, the youngest hit is necessarily that entry.
    assign coalesce = Dwrite && |(hit & ~head_hot);
`else
    logic unused_hit;
    assign unused_hit = ^hit;
    assign coalesce   = 1'b0;
`endif

    assign alloc = Dwrite && !coalesce && (!wb_full || pop);

    always_comb begin
        Din = mem_rdata;
        if (Dread && !Dwrite && any_hit) begin
            Din = e_data[hit_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (MRST) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            e_valid    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            // When full with a pop, tail == head: the later set wins so the slot stays valid.
            if (alloc) begin
                e_valid[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (alloc && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !alloc) begin
                count <= count - 1'b1;
            end
            if (Dwrite && !coalesce && wb_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (alloc) begin
            e_addr[tail] <= Daddr;
            e_data[tail] <= Dout;
        end else if (coalesce) begin
            e_data[hit_idx] <= Dout;
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: scoreboard of expected memory writes plus
// forwarding, status-flag and reset checks. Honours DWB_COALESCE_EN when defined.
module tb_dmem_write_buffer;

    logic        CLK = 1'b0;
    logic        MRST;
    logic [31:0] Daddr;
    logic        Dread;
    logic        Dwrite;
    logic [31:0] Dout;
    logic [31:0] Din;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wreq;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wack;
    logic        wb_full;
    logic        wb_empty;
    logic        wb_overflow;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] qa[$];
    logic [31:0] qd[$];

    dmem_write_buffer dut (
        .CLK         (CLK),
        .MRST        (MRST),
        .Daddr       (Daddr),
        .Dread       (Dread),
        .Dwrite      (Dwrite),
        .Dout        (Dout),
        .Din         (Din),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .mem_wreq    (mem_wreq),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wack    (mem_wack),
        .wb_full     (wb_full),
        .wb_empty    (wb_empty),
        .wb_overflow (wb_overflow)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks follow 2 units later.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic ack);
        Dread     = rd;
        Dwrite    = wr;
        Daddr     = a;
        Dout      = d;
        mem_wack  = ack;
        mem_rdata = rdata_of(a);
        #2;
    endtask

    task automatic tick();
        logic [31:0] ea;
        logic [31:0] ed;
        if (!MRST && mem_wreq && mem_wack) begin
            if (qa.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL unexpected_write: observed addr %h expected no write", mem_waddr);
            end else begin
                ea = qa.pop_front();
                ed = qd.pop_front();
                chk("drain_addr", mem_waddr, ea);
                chk("drain_data", mem_wdata, ed);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic ack);
        drive(1'b0, 1'b1, a, d, ack);
        qa.push_back(a);
        qd.push_back(d);
        tick();
    endtask

    task automatic drain_all();
        int n;
        n = qa.size();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < n; i++) tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("drained_empty", 32'(wb_empty), 32'd1);
        chk("sb_drained", 32'(qa.size()), 32'd0);
    endtask

    task automatic do_reset();
        MRST = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        qa.delete();
        qd.delete();
        MRST = 1'b0;
    endtask

    initial begin
        MRST = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_empty", 32'(wb_empty), 32'd1);
        chk("rst_full", 32'(wb_full), 32'd0);
        chk("rst_wreq", 32'(mem_wreq), 32'd0);
        chk("rst_ovf", 32'(wb_overflow), 32'd0);
        MRST = 1'b0;

        // Store then forward on the next cycle
        drive(1'b0, 1'b1, 32'h100, 32'hAAAA_5555, 1'b0);
        chk("wreq_before_store", 32'(mem_wreq), 32'd0);
        qa.push_back(32'h100);
        qd.push_back(32'hAAAA_5555);
        tick();
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        chk("fwd_din", Din, 32'hAAAA_5555);
        chk("fwd_wreq", 32'(mem_wreq), 32'd1);
        chk("fwd_waddr", mem_waddr, 32'h100);
        chk("raddr", mem_raddr, 32'h100);
        drive(1'b1, 1'b0, 32'h102, 32'h0, 1'b0);
        chk("fwd_byte_off", Din, 32'hAAAA_5555);
        drive(1'b1, 1'b0, 32'h104, 32'h0, 1'b0);
        chk("nofwd_104", Din, rdata_of(32'h104));
        drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0);
        chk("nofwd_300", Din, rdata_of(32'h300));
        drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
        chk("no_dread", Din, rdata_of(32'h100));
        drive(1'b1, 1'b1, 32'h100, 32'h77, 1'b0);
        chk("rd_wr_both", Din, rdata_of(32'h100));
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1);
        chk("fwd_while_pop", Din, 32'hAAAA_5555);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("sb_drained1", 32'(qa.size()), 32'd0);
        chk("empty_after_pop", 32'(wb_empty), 32'd1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 4; i++) store(32'h10 + 32'(i) * 4, 32'h1000 + 32'(i), 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("fill_full", 32'(wb_full), 32'd1);
        chk("fill_ovf0", 32'(wb_overflow), 32'd0);
        drive(1'b0, 1'b1, 32'h20, 32'hBAD0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("ovf_set", 32'(wb_overflow), 32'd1);
        chk("ovf_full", 32'(wb_full), 32'd1);
        chk("ovf_dropped_nofwd", Din, rdata_of(32'h20));
        drain_all();
        chk("ovf_sticky", 32'(wb_overflow), 32'd1);

        // Full with a simultaneous pop accepts the store
        do_reset();
        chk("rst2_ovf", 32'(wb_overflow), 32'd0);
        for (int i = 0; i < 4; i++) store(32'h40 + 32'(i) * 4, 32'h4000 + 32'(i), 1'b0);
        store(32'h50, 32'h55, 1'b1);
        drive(1'b1, 1'b0, 32'h50, 32'h0, 1'b0);
        chk("pp_full", 32'(wb_full), 32'd1);
        chk("pp_ovf", 32'(wb_overflow), 32'd0);
        chk("pp_head", mem_waddr, 32'h44);
        chk("pp_fwd", Din, 32'h55);
        drain_all();

        // Duplicate stores to one word
        store(32'h1F0, 32'h7, 1'b0);
        store(32'h200, 32'h1, 1'b0);
        drive(1'b0, 1'b1, 32'h200, 32'h2, 1'b0);
`ifdef DWB_COALESCE_EN
        qd[qd.size() - 1] = 32'h2;
`else
        qa.push_back(32'h200);
        qd.push_back(32'h2);
`endif
        tick();
        store(32'h1F0, 32'h8, 1'b0);
        drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
        chk("dup_fwd_200", Din, 32'h2);
        drive(1'b1, 1'b0, 32'h1F0, 32'h0, 1'b0);
        chk("dup_fwd_1f0", Din, 32'h8);
`ifdef DWB_COALESCE_EN
        chk("dup_full", 32'(wb_full), 32'd0);
`else
        chk("dup_full", 32'(wb_full), 32'd1);
`endif
        drain_all();

        // Reset mid-drain discards everything
        for (int i = 0; i < 4; i++) store(32'h600 + 32'(i) * 4, 32'h6000 + 32'(i), 1'b0);
        drive(1'b0, 1'b1, 32'h610, 32'hBAD1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("ovf_before_rst", 32'(wb_overflow), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("mid_drain_wreq", 32'(mem_wreq), 32'd1);
        MRST = 1'b1;
        drive(1'b0, 1'b1, 32'h700, 32'h70, 1'b1);
        tick();
        qa.delete();
        qd.delete();
        MRST = 1'b0;
        drive(1'b1, 1'b0, 32'h604, 32'h0, 1'b1);
        chk("rst_mid_wreq", 32'(mem_wreq), 32'd0);
        chk("rst_mid_empty", 32'(wb_empty), 32'd1);
        chk("rst_mid_full", 32'(wb_full), 32'd0);
        chk("rst_mid_ovf", 32'(wb_overflow), 32'd0);
        chk("rst_mid_nofwd", Din, rdata_of(32'h604));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_wreq", 32'(mem_wreq), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
